bitmap_packer: RTL and testbench

BITMAP_PACKER -- requirements
Module: bitmap_packer

---
 rtl/bitmap_packer_if.sv | 27 ++
 rtl/bitmap_packer.sv | 106 ++++++++++
 tb/tb_bitmap_packer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bitmap_packer_if.sv
// Bit-in / word-out bundle for bitmap_packer: decision bits in, packed words out.
// Master drives the word side and flow status; slave drives bits and consumer ready.
interface bitmap_packer_if #(
    parameter int W  = 8,
    parameter int CW = 17
);
    logic          iEN;
    logic          iDATA;
    logic          oFULL;
    logic [CW-1:0] oADDR;
    logic [W-1:0]  oWORD;
    logic          oVALID;
    logic          iREADY;
    logic          oLAST;
    logic [CW-1:0] oCOUNT;
    logic          oOVF;

    modport master (
        input  iEN, iDATA, iREADY,
        output oFULL, oADDR, oWORD, oVALID, oLAST, oCOUNT, oOVF
    );

    modport slave (
        output iEN, iDATA, iREADY,
        input  oFULL, oADDR, oWORD, oVALID, oLAST, oCOUNT, oOVF
    );
endinterface

// File: rtl/bitmap_packer.sv
// Packs comparator bits LSB-first into W-bit words with a per-frame ones count; 1-cycle latency.
// 2-entry output queue; while full, incoming bits are dropped and a sticky overflow flag is raised.
module bitmap_packer #(
    parameter int W    = 8,
    parameter int NBIN = 1024,
    parameter int CW   = 17
) (
    input  logic             iCLK,
    input  logic             iRST,
    bitmap_packer_if.master  bus
);
    localparam int PW = (W > 1) ? $clog2(W) : 1;

    logic [CW-1:0] bidx_q, bidx_d;
    logic [PW-1:0] pos_q, pos_d;
    logic [W-1:0]  pack_q, pack_d;
    logic [CW-1:0] ones_q, ones_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    occ_q, occ_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  word_mem_q [2];
    logic          last_mem_q [2];
    logic [CW-1:0] cnt_mem_q  [2];

    logic          full, valid, accept, frame_end, word_end, push, pop;
    logic [W-1:0]  word_new;
    logic [CW-1:0] ones_new;

    always_comb begin
        full      = (occ_q == 2'd2);
        valid     = (occ_q != 2'd0);
        accept    = bus.iEN & ~full;
        frame_end = (bidx_q == CW'(NBIN - 1));
        // pos_q tracks bidx mod W without a divider; it restarts with each frame
        word_end  = frame_end | (pos_q == PW'(W - 1));
        push      = accept & word_end;
        pop       = valid & bus.iREADY;

        word_new          = pack_q;
        word_new[pos_q]   = bus.iDATA;
        ones_new          = ones_q + CW'(bus.iDATA);

        bidx_d = bidx_q;
        pos_d  = pos_q;
        pack_d = pack_q;
        ones_d = ones_q;
        if (accept) begin
            bidx_d = frame_end ? '0 : bidx_q + CW'(1);
            pos_d  = word_end  ? '0 : pos_q + PW'(1);
            pack_d = word_end  ? '0 : word_new;
            ones_d = frame_end ? '0 : ones_new;
        end

        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;
        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        ovf_d = ovf_q | (bus.iEN & full);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bidx_q <= '0;
            pos_q  <= '0;
            pack_q <= '0;
            ones_q <= '0;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            occ_q  <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            bidx_q <= bidx_d;
            pos_q  <= pos_d;
            pack_q <= pack_d;
            ones_q <= ones_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
        end
    end

    // Queue storage needs no reset: every read path is gated by occupancy
    always_ff @(posedge iCLK) begin
        if (push && !iRST) begin
            word_mem_q[wr_q] <= word_new;
            last_mem_q[wr_q] <= frame_end;
            cnt_mem_q[wr_q]  <= frame_end ? ones_new : '0;
        end
    end

    assign bus.oFULL  = full;
    assign bus.oADDR  = bidx_q;
    assign bus.oVALID = valid;
    assign bus.oWORD  = valid ? word_mem_q[rd_q] : '0;
    assign bus.oLAST  = valid & last_mem_q[rd_q];
    assign bus.oCOUNT = (valid && last_mem_q[rd_q]) ? cnt_mem_q[rd_q] : '0;
    assign bus.oOVF   = ovf_q;
endmodule

// File: tb/tb_bitmap_packer.sv
// Directed bench for bitmap_packer at W=8, NBIN=20; popped words are gathered and compared per scenario.
module tb_bitmap_packer;
    localparam int W    = 8;
    localparam int NBIN = 20;
    localparam int CW   = 17;

    logic iCLK = 1'b0;
    logic iRST;

    bitmap_packer_if #(.W(W), .CW(CW)) bus ();

    bitmap_packer #(.W(W), .NBIN(NBIN), .CW(CW)) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [W-1:0]  w;
        logic          l;
        logic [CW-1:0] c;
    } ent_t;

    ent_t got_q[$];
    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always @(negedge iCLK) begin
        if (!iRST && bus.oVALID && bus.iREADY) begin
            ent_t e;
            e.w = bus.oWORD;
            e.l = bus.oLAST;
            e.c = bus.oCOUNT;
            got_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.iEN   = 1'b1;
        bus.iDATA = b;
        step();
        bus.iEN   = 1'b0;
    endtask

    task automatic expect_word(input logic [W-1:0] w, input logic l, input int c);
        ent_t e;
        e.w = w;
        e.l = l;
        e.c = CW'(c);
        exp_q.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        chk({tag, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), got_q[i].w, exp_q[i].w);
            chk($sformatf("%s_last%0d", tag, i), got_q[i].l, exp_q[i].l);
            chk($sformatf("%s_cnt%0d", tag, i),  got_q[i].c, exp_q[i].c);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] w1, w2, tail;

        // Reset held 2 cycles with iEN high, which must be ignored
        iRST       = 1'b1;
        bus.iEN    = 1'b1;
        bus.iDATA  = 1'b1;
        bus.iREADY = 1'b0;
        step();
        step();
        iRST    = 1'b0;
        bus.iEN = 1'b0;
        chk("rst_addr",  bus.oADDR,  0);
        chk("rst_valid", bus.oVALID, 0);
        chk("rst_word",  bus.oWORD,  0);
        chk("rst_last",  bus.oLAST,  0);
        chk("rst_count", bus.oCOUNT, 0);
        chk("rst_full",  bus.oFULL,  0);
        chk("rst_ovf",   bus.oOVF,   0);

        // Basic frame: alternating 1,0 with consumer always ready
        bus.iREADY = 1'b1;
        for (int i = 0; i < NBIN; i++) begin
            send_bit((i % 2) == 0);
            if (i == 7) begin
                chk("lat_valid", bus.oVALID, 1);
                chk("lat_word",  bus.oWORD,  8'h55);
            end
        end
        step();
        step();
        chk("basic_addr", bus.oADDR, 0);
        expect_word(8'h55, 1'b0, 0);
        expect_word(8'h55, 1'b0, 0);
        expect_word(8'h05, 1'b1, 10);
        compare_out("basic");

        // Backpressure: 17 ones with no consumer
        bus.iREADY = 1'b0;
        for (int i = 0; i < 16; i++) send_bit(1'b1);
        chk("bp_full16", bus.oFULL, 1);
        chk("bp_addr16", bus.oADDR, 16);
        chk("bp_ovf16",  bus.oOVF,  0);
        send_bit(1'b1);
        chk("bp_addr17", bus.oADDR, 16);
        chk("bp_ovf17",  bus.oOVF,  1);
        chk("bp_full17", bus.oFULL, 1);
        chk("bp_head",   bus.oWORD, 8'hFF);
        step();
        chk("bp_hold",   bus.oWORD, 8'hFF);

        // Drain
        bus.iREADY = 1'b1;
        step();
        step();
        step();
        chk("drain_full",  bus.oFULL,  0);
        chk("drain_ovf",   bus.oOVF,   1);
        chk("drain_valid", bus.oVALID, 0);
        expect_word(8'hFF, 1'b0, 0);
        expect_word(8'hFF, 1'b0, 0);
        compare_out("drain");

        // Close that frame: 16 ones accepted, 4 zeros to finish
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        step();
        step();
        chk("close_addr", bus.oADDR, 0);
        expect_word(8'h00, 1'b1, 16);
        compare_out("close");

        // Simultaneous push and pop at occupancy 1
        w1   = 8'h3C;
        w2   = 8'hC3;
        tail = 8'h0B;
        bus.iREADY = 1'b0;
        for (int j = 0; j < 8; j++) send_bit(w1[j]);
        for (int j = 0; j < 7; j++) send_bit(w2[j]);
        chk("pp_pre_valid", bus.oVALID, 1);
        chk("pp_pre_full",  bus.oFULL,  0);
        bus.iREADY = 1'b1;
        send_bit(w2[7]);
        chk("pp_valid", bus.oVALID, 1);
        chk("pp_full",  bus.oFULL,  0);
        chk("pp_head",  bus.oWORD,  8'hC3);
        step();
        chk("pp_empty", bus.oVALID, 0);
        for (int j = 0; j < 4; j++) send_bit(tail[j]);
        step();
        step();
        expect_word(8'h3C, 1'b0, 0);
        expect_word(8'hC3, 1'b0, 0);
        expect_word(8'h0B, 1'b1, 11);
        compare_out("pp");

        // Reset mid-frame, then a frame of zeros
        bus.iREADY = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("mid_addr5", bus.oADDR, 5);
        iRST      = 1'b1;
        bus.iEN   = 1'b1;
        bus.iDATA = 1'b1;
        step();
        iRST    = 1'b0;
        bus.iEN = 1'b0;
        chk("mid_addr",  bus.oADDR,  0);
        chk("mid_ovf",   bus.oOVF,   0);
        chk("mid_valid", bus.oVALID, 0);
        bus.iREADY = 1'b1;
        for (int i = 0; i < NBIN; i++) send_bit(1'b0);
        step();
        step();
        expect_word(8'h00, 1'b0, 0);
        expect_word(8'h00, 1'b0, 0);
        expect_word(8'h00, 1'b1, 0);
        compare_out("mid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
